// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encoding and sizing helper for the multi-channel debouncer
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE0 = 2'd0,
        WAIT1   = 2'd1,
        STABLE1 = 2'd2,
        WAIT0   = 2'd3
    } db_state_t;

    // Counter width that never collapses to zero bits for tiny parameter values
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one debounce lane: synchroniser, wait/stable FSM, registered level and edge pulses
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int   STABLE_TICKS = 3,
    parameter int   SYNC_STAGES  = 2,
    parameter logic RESET_VAL    = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic sw,
    output logic db,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int             CW       = clog2_min1(STABLE_TICKS + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    db_state_t              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   db_d, rise_d, fall_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // A level flip toward s wins over a tick arriving in the same cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        db_d    = db;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE0: begin
                if (s) begin
                    state_d = WAIT1;
                    cnt_d   = '0;
                end
            end
            WAIT1: begin
                if (!s) begin
                    state_d = STABLE0;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = STABLE1;
                        cnt_d   = '0;
                        db_d    = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            STABLE1: begin
                if (!s) begin
                    state_d = WAIT0;
                    cnt_d   = '0;
                end
            end
            WAIT0: begin
                if (s) begin
                    state_d = STABLE1;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = STABLE0;
                        cnt_d   = '0;
                        db_d    = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = db ? STABLE1 : STABLE0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RESET_VAL ? STABLE1 : STABLE0;
            cnt_q   <= '0;
            db      <= RESET_VAL;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db      <= db_d;
            rise    <= rise_d;
            fall    <= fall_d;
        end
    end

    assign busy = (state_q == WAIT1) || (state_q == WAIT0);

endmodule

// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - N-channel debouncer with one shared sample-tick prescaler
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int   NUM_CH       = 4,
    parameter int   TICK_DIV     = 100000,
    parameter int   STABLE_TICKS = 3,
    parameter int   SYNC_STAGES  = 2,
    parameter logic RESET_VAL    = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] sw,
    output logic [NUM_CH-1:0] db,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall,
    output logic [NUM_CH-1:0] busy
);

    localparam int            DW       = clog2_min1(TICK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic          tick;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        debounce_channel #(
            .STABLE_TICKS(STABLE_TICKS),
            .SYNC_STAGES (SYNC_STAGES),
            .RESET_VAL   (RESET_VAL)
        ) u_ch (
            .clk  (clk),
            .reset(reset),
            .tick (tick),
            .sw   (sw[ch]),
            .db   (db[ch]),
            .rise (rise[ch]),
            .fall (fall[ch]),
            .busy (busy[ch])
        );
    end

endmodule

// File: tb/tb_debounce_multi.sv
// tb/tb_debounce_multi.sv - randomized and directed bench for debounce_multi against a tick-counting reference model
module tb_debounce_multi;

    localparam int NC = 4;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NC-1:0] sw = '0;
    logic [NC-1:0] db0, rise0, fall0, busy0;
    logic [NC-1:0] db1, rise1, fall1, busy1;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a channel is "pending" from the first cycle s differs from db;
    // it flips once STABLE_TICKS ticks have occurred strictly after that cycle.
    int            tdv [2] = '{4, 1};
    int            stv [2] = '{3, 1};
    logic          m_db   [2][NC];
    logic          m_rise [2][NC];
    logic          m_fall [2][NC];
    int            m_since[2][NC];
    logic [SS-1:0] m_pipe [2][NC];
    int            m_k;

    always #5 clk = ~clk;

    debounce_multi #(
        .NUM_CH(NC), .TICK_DIV(4), .STABLE_TICKS(3), .SYNC_STAGES(SS), .RESET_VAL(1'b0)
    ) dut0 (
        .clk(clk), .reset(reset), .sw(sw), .db(db0), .rise(rise0), .fall(fall0), .busy(busy0)
    );

    debounce_multi #(
        .NUM_CH(NC), .TICK_DIV(1), .STABLE_TICKS(1), .SYNC_STAGES(SS), .RESET_VAL(1'b0)
    ) dut1 (
        .clk(clk), .reset(reset), .sw(sw), .db(db1), .rise(rise1), .fall(fall1), .busy(busy1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NC; c++) begin
                m_db[d][c]    = 1'b0;
                m_rise[d][c]  = 1'b0;
                m_fall[d][c]  = 1'b0;
                m_since[d][c] = -1;
                m_pipe[d][c]  = '0;
            end
        end
        m_k = 0;
    endtask

    task automatic model_edge();
        logic s;
        int   ticks;
        if (!reset) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NC; c++) begin
                s = m_pipe[d][c][SS-1];
                m_rise[d][c] = 1'b0;
                m_fall[d][c] = 1'b0;
                if (s == m_db[d][c]) begin
                    m_since[d][c] = -1;
                end else begin
                    if (m_since[d][c] < 0) m_since[d][c] = m_k;
                    ticks = (m_k + 1) / tdv[d] - (m_since[d][c] + 1) / tdv[d];
                    if (ticks >= stv[d]) begin
                        m_db[d][c]    = s;
                        m_rise[d][c]  = s;
                        m_fall[d][c]  = !s;
                        m_since[d][c] = -1;
                    end
                end
                m_pipe[d][c] = {m_pipe[d][c][SS-2:0], sw[c]};
            end
        end
        m_k++;
    endtask

    function automatic logic [15:0] exp_vec(input int d);
        logic [15:0] v;
        for (int c = 0; c < NC; c++) begin
            v[c]      = m_db[d][c];
            v[4 + c]  = m_rise[d][c];
            v[8 + c]  = m_fall[d][c];
            v[12 + c] = (m_since[d][c] >= 0);
        end
        return v;
    endfunction

    task automatic check_outputs(input string tag);
        check_eq({tag, " dut0"}, {16'h0, busy0, fall0, rise0, db0}, {16'h0, exp_vec(0)});
        check_eq({tag, " dut1"}, {16'h0, busy1, fall1, rise1, db1}, {16'h0, exp_vec(1)});
    endtask

    // Called at a negedge: check, drive next input, advance one clock
    task automatic step(input logic [NC-1:0] sw_next, input string tag);
        check_outputs(tag);
        sw = sw_next;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        int rc, fc, lat;
        int hold [NC];
        logic [NC-1:0] rs;

        model_reset();
        reset = 1'b0;
        sw    = 4'hF;
        @(negedge clk);

        // Reset held with all inputs high, then released
        repeat (3) step(4'hF, "rst_hold");
        check_eq("rst_db", {28'h0, db0}, 32'h0);
        check_eq("rst_busy", {28'h0, busy0}, 32'h0);
        reset = 1'b1;
        repeat (40) step(4'hF, "t1_up");
        check_eq("t1_db_up", {28'h0, db0}, 32'hF);
        repeat (40) step(4'h0, "t1_down");

        // Clean press on ch0
        rc = 0; fc = 0; lat = -1;
        for (int i = 0; i < 30; i++) begin
            step(4'h1, "t2");
            if (rise0[0]) rc++;
            if (fall0[0]) fc++;
            if (db0[0] && lat < 0) lat = i + 1;
            if (i == 2) check_eq("t2_busy", {31'h0, busy0[0]}, 32'h1);
        end
        check_eq("t2_rise_cnt", rc, 1);
        check_eq("t2_fall_cnt", fc, 0);
        check_eq("t2_lat_window", {31'h0, (lat >= 11 && lat <= 14)}, 32'h1);

        // Bounce on ch1 every 5 clk, then held low
        rc = 0;
        for (int i = 0; i < 60; i++) begin
            step({2'b00, (i < 40) ? (((i / 5) % 2) == 0) : 1'b0, 1'b1}, "t3");
            if (rise0[1]) rc++;
        end
        check_eq("t3_rise_cnt", rc, 0);
        check_eq("t3_db1", {31'h0, db0[1]}, 32'h0);
        check_eq("t3_busy1", {31'h0, busy0[1]}, 32'h0);

        // Release on ch2 after it has settled high
        repeat (20) step(4'b0101, "t4_up");
        fc = 0; lat = -1;
        for (int i = 0; i < 30; i++) begin
            step(4'b0001, "t4");
            if (fall0[2]) fc++;
            if (!db0[2] && lat < 0) lat = i + 1;
        end
        check_eq("t4_fall_cnt", fc, 1);
        check_eq("t4_lat_window", {31'h0, (lat >= 11 && lat <= 14)}, 32'h1);

        // Independence: 1010 applied together, ch3 bounces before settling
        for (int i = 0; i < 50; i++) begin
            step({(i < 30) ? (((i / 3) % 2) == 0) : 1'b1, 3'b010}, "t5");
            if (i == 20) check_eq("t5_db_mid", {28'h0, db0}, 32'h2);
        end
        check_eq("t5_db_end", {28'h0, db0}, 32'hA);

        // Async reset in the middle of WAIT1 on ch0
        repeat (30) step(4'h0, "t6_settle");
        repeat (6) step(4'h1, "t6_wait");
        check_eq("t6_busy_pre", {31'h0, busy0[0]}, 32'h1);
        #2 reset = 1'b0;
        #1;
        check_eq("t6_db_async", {31'h0, db0[0]}, 32'h0);
        check_eq("t6_busy_async", {31'h0, busy0[0]}, 32'h0);
        check_eq("t6_rise_async", {31'h0, rise0[0]}, 32'h0);
        model_reset();
        sw = 4'h0;
        @(negedge clk);
        repeat (2) step(4'h0, "t6_rst");
        reset = 1'b1;
        rc = 0;
        for (int i = 0; i < 30; i++) begin
            step(4'h0, "t6_after");
            if (rise0[0] || rise1[0]) rc++;
        end
        check_eq("t6_no_pulse", rc, 0);

        // TICK_DIV=1, STABLE_TICKS=1: db follows s two clocks later
        lat = -1;
        for (int i = 0; i < 8; i++) begin
            step(4'h1, "t6b");
            if (db1[0] && lat < 0) lat = i + 1;
        end
        check_eq("t6b_latency", lat, 4);

        // Randomized hold lengths per channel
        for (int c = 0; c < NC; c++) hold[c] = 1;
        rs = sw;
        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < NC; c++) begin
                hold[c]--;
                if (hold[c] <= 0) begin
                    rs[c]   = ~rs[c];
                    hold[c] = (($urandom % 3) == 0) ? $urandom_range(25, 10) : $urandom_range(6, 1);
                end
            end
            step(rs, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
